uart_rx_frame_monitor: RTL and testbench

UART_RX_FRAME_MONITOR -- requirements
Module: uart_rx_frame_monitor

---
 rtl/uart_rx_frame_monitor.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_frame_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_monitor.sv
// Passive UART receive monitor: snoops APB config writes for line format/baud,
// decodes frames from the observed serial line and flags parity/framing errors.
module uart_rx_frame_monitor #(
  parameter        INST_NAME = "uart_mon",
  parameter int    ADDR_W    = 32
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  input  logic              uart_net,
  output logic              frame_valid,
  output logic [7:0]        frame_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic [15:0]       err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic        r_sync1, r_sync2, r_line_d, r_brk_wait;
  logic        r_mdr_osm;
  logic [7:0]  r_dll, r_dlh;
  logic [4:0]  r_lcr;
  logic [15:0] r_div_max;
  logic        r_osr13, r_stop2, r_pen, r_eps;
  logic [1:0]  r_wls;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_data;
  logic        r_perr, r_ferr;

  logic        w_cfg_wr, w_mdr_nx;
  logic [7:0]  w_dll_nx, w_dlh_nx;
  logic [4:0]  w_lcr_nx;
  logic [15:0] w_div_nx, w_div_max_nx;
  logic        w_start, w_tick, w_bit_tick, w_last_data, w_frame_end, w_ferr_final;
  logic [3:0]  w_tick_target;
  logic        w_unused;

  // Expected parity bit: odd parity when eps=0, even parity when eps=1
  function automatic logic f_exp_parity(input logic [7:0] d, input logic eps);
    return (^d) ^ ~eps;
  endfunction

  assign w_cfg_wr = psel & penable & pwrite & pstrb[0];
  assign w_mdr_nx = (w_cfg_wr && paddr[7:0] == 8'h00) ? pwdata[0]   : r_mdr_osm;
  assign w_dll_nx = (w_cfg_wr && paddr[7:0] == 8'h04) ? pwdata[7:0] : r_dll;
  assign w_dlh_nx = (w_cfg_wr && paddr[7:0] == 8'h08) ? pwdata[7:0] : r_dlh;
  assign w_lcr_nx = (w_cfg_wr && paddr[7:0] == 8'h0C) ? pwdata[4:0] : r_lcr;
  assign w_div_nx = {w_dlh_nx, w_dll_nx};
  assign w_div_max_nx = (w_div_nx == 16'd0) ? 16'd0 : (w_div_nx - 16'd1);

  // Start-bit midpoint comes OSR/2 ticks in; every later bit OSR ticks on
  assign w_tick_target = (r_state == S_START) ? (r_osr13 ? 4'd5 : 4'd7)
                                              : (r_osr13 ? 4'd12 : 4'd15);
  assign w_start      = (r_state == S_IDLE) && r_line_d && !r_sync2 && !r_brk_wait;
  assign w_tick       = (r_div_cnt == r_div_max);
  assign w_bit_tick   = w_tick && (r_tick_cnt == w_tick_target);
  assign w_last_data  = (r_bit_cnt == (3'd4 + {1'b0, r_wls}));
  assign w_ferr_final = (r_state == S_STOP1) ? ~r_sync2 : r_ferr;
  assign w_unused     = ^{paddr, pwdata[31:8], pstrb[3:1]};

  // FSM state register
  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state and end-of-frame decode
  always_comb begin
    w_state_nx  = r_state;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nx = S_START;
        else         w_state_nx = S_IDLE;
      end
      S_START: begin
        if (w_bit_tick) w_state_nx = r_sync2 ? S_IDLE : S_DATA;
        else            w_state_nx = S_START;
      end
      S_DATA: begin
        if (w_bit_tick && w_last_data) w_state_nx = r_pen ? S_PARITY : S_STOP1;
        else                           w_state_nx = S_DATA;
      end
      S_PARITY: begin
        if (w_bit_tick) w_state_nx = S_STOP1;
        else            w_state_nx = S_PARITY;
      end
      S_STOP1: begin
        if (w_bit_tick) begin
          w_state_nx  = r_stop2 ? S_STOP2 : S_IDLE;
          w_frame_end = ~r_stop2;
        end else begin
          w_state_nx  = S_STOP1;
        end
      end
      S_STOP2: begin
        if (w_bit_tick) begin
          w_state_nx  = S_IDLE;
          w_frame_end = 1'b1;
        end else begin
          w_state_nx  = S_STOP2;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Line sync, config snoop, bit timing, shift register and frame outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_sync1 <= 1'b1;  r_sync2 <= 1'b1;  r_line_d <= 1'b1;  r_brk_wait <= 1'b0;
      r_mdr_osm <= 1'b0;  r_dll <= 8'h00;  r_dlh <= 8'h00;  r_lcr <= 5'h00;
      r_div_max <= 16'd0;  r_osr13 <= 1'b0;  r_wls <= 2'd0;
      r_stop2 <= 1'b0;  r_pen <= 1'b0;  r_eps <= 1'b0;
      r_div_cnt <= 16'd0;  r_tick_cnt <= 4'd0;  r_bit_cnt <= 3'd0;
      r_data <= 8'h00;  r_perr <= 1'b0;  r_ferr <= 1'b0;
      frame_valid <= 1'b0;  frame_data <= 8'h00;
      parity_err <= 1'b0;  frame_err <= 1'b0;  err_cnt <= 16'd0;
    end else begin
      r_sync1   <= uart_net;
      r_sync2   <= r_sync1;
      r_line_d  <= r_sync2;
      r_mdr_osm <= w_mdr_nx;
      r_dll     <= w_dll_nx;
      r_dlh     <= w_dlh_nx;
      r_lcr     <= w_lcr_nx;

      if (r_state == S_IDLE) begin
        r_div_cnt  <= 16'd0;
        r_tick_cnt <= 4'd0;
        if (w_start) begin
          r_div_max <= w_div_max_nx;
          r_osr13   <= w_mdr_nx;
          r_wls     <= w_lcr_nx[1:0];
          r_stop2   <= w_lcr_nx[2];
          r_pen     <= w_lcr_nx[3];
          r_eps     <= w_lcr_nx[4];
          r_bit_cnt <= 3'd0;
          r_data    <= 8'h00;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
        end
      end else begin
        r_div_cnt <= w_tick ? 16'd0 : (r_div_cnt + 16'd1);
        if (w_tick) r_tick_cnt <= w_bit_tick ? 4'd0 : (r_tick_cnt + 4'd1);
      end

      if (w_bit_tick) begin
        case (r_state)
          S_DATA: begin
            r_data[r_bit_cnt] <= r_sync2;
            r_bit_cnt         <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_perr <= (r_sync2 != f_exp_parity(r_data, r_eps));
          S_STOP1:  r_ferr <= ~r_sync2;
          default:  ;
        endcase
      end

      // Break: after a framing error, hold off new starts until the line idles high
      if (w_frame_end)  r_brk_wait <= w_ferr_final;
      else if (r_sync2) r_brk_wait <= 1'b0;

      frame_valid <= w_frame_end;
      if (w_frame_end) begin
        frame_data <= r_data;
        parity_err <= r_perr;
        frame_err  <= w_ferr_final;
      end

      if (frame_valid && (parity_err || frame_err) && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_monitor.sv
// Self-checking bench: directed scenarios plus randomized frames, checked against
// a frame-level model of line format, parity and error counting.
module tb_uart_rx_frame_monitor;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite, uart_net;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        frame_valid, parity_err, frame_err;
  logic [7:0]  frame_data;
  logic [15:0] err_cnt;

  int tests = 0, fails = 0;
  int fv_cnt = 0, exp_fv = 0, exp_err = 0;
  int m_osr = 16, m_div = 1, m_nb = 5;
  logic m_stop2 = 1'b0, m_pen = 1'b0, m_eps = 1'b0;

  always #5 pclk = ~pclk;

  uart_rx_frame_monitor dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .uart_net(uart_net),
    .frame_valid(frame_valid), .frame_data(frame_data), .parity_err(parity_err),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always @(negedge pclk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic wr);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk) penable = 1'b1;
    @(negedge pclk) begin psel = 1'b0; penable = 1'b0; pwrite = 1'b0; end
  endtask

  task automatic model_cfg(input logic osr13, input int dll, input logic [7:0] lcr);
    m_osr   = osr13 ? 13 : 16;
    m_div   = (dll == 0) ? 1 : dll;
    m_nb    = int'(lcr[1:0]) + 5;
    m_stop2 = lcr[2];
    m_pen   = lcr[3];
    m_eps   = lcr[4];
  endtask

  task automatic set_cfg(input logic osr13, input int dll, input logic [7:0] lcr);
    apb_write(32'h00, {31'd0, osr13}, 4'hF, 1'b1);
    apb_write(32'h04, dll, 4'hF, 1'b1);
    apb_write(32'h08, 32'h0, 4'hF, 1'b1);
    apb_write(32'h0C, {24'd0, lcr}, 4'hF, 1'b1);
    model_cfg(osr13, dll, lcr);
    wait_cyc(4);
  endtask

  function automatic logic good_pbit(input logic [7:0] d, input logic eps);
    int ones = $countones(d);
    return eps ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  // Drive one frame with bit period bitp, then check the decoded result
  task automatic do_frame(input string tag, input logic [7:0] d_raw, input logic inj_par,
                          input logic s1_bad, input logic brk);
    int bitp = m_osr * m_div;
    int nb = m_nb;
    int mk = (1 << nb) - 1;
    logic pen = m_pen, two = m_stop2;
    logic [7:0] d = d_raw & mk[7:0];
    logic pbit = good_pbit(d, m_eps) ^ inj_par;
    logic s1 = ~(s1_bad | brk);
    logic e_perr = pen & inj_par;
    logic e_ferr = ~s1;
    uart_net = 1'b0; wait_cyc(bitp);
    for (int i = 0; i < nb; i++) begin uart_net = d[i]; wait_cyc(bitp); end
    if (pen) begin uart_net = pbit; wait_cyc(bitp); end
    uart_net = s1; wait_cyc(bitp);
    if (two) begin uart_net = ~brk; wait_cyc(bitp); end
    uart_net = ~brk; wait_cyc(4);
    exp_fv++;
    if ((e_perr || e_ferr) && exp_err < 65535) exp_err++;
    for (int i = 0; i < 400 && fv_cnt < exp_fv; i++) @(negedge pclk);
    wait_cyc(2);
    chk({tag, ".fv_cnt"}, fv_cnt, exp_fv);
    chk({tag, ".data"}, {24'd0, frame_data}, {24'd0, d});
    chk({tag, ".parity_err"}, {31'd0, parity_err}, {31'd0, e_perr});
    chk({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, e_ferr});
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, exp_err);
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; uart_net = 1'b1;
    wait_cyc(3);
    chk("rst.frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst.frame_data", {24'd0, frame_data}, 32'd0);
    chk("rst.parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst.frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst.err_cnt", {16'd0, err_cnt}, 32'd0);
    preset = 1'b0;
    wait_cyc(4);

    set_cfg(1'b0, 2, 8'h03);
    do_frame("8n1_a5", 8'hA5, 1'b0, 1'b0, 1'b0);

    set_cfg(1'b0, 2, 8'h1B);
    do_frame("8e1_par", 8'h03, 1'b1, 1'b0, 1'b0);

    // Writes that must be ignored: no byte-0 strobe, a read, an undecoded address
    apb_write(32'h0C, 32'h03, 4'hE, 1'b1);
    apb_write(32'h0C, 32'h03, 4'hF, 1'b0);
    apb_write(32'h10, 32'h03, 4'hF, 1'b1);
    wait_cyc(4);
    do_frame("ignored_wr", 8'h5A, 1'b0, 1'b0, 1'b0);

    set_cfg(1'b1, 2, 8'h04);
    do_frame("5n2_brk", 8'h15, 1'b0, 1'b0, 1'b1);
    wait_cyc(3 * m_osr * m_div);
    chk("brk.hold_fv", fv_cnt, exp_fv);
    uart_net = 1'b1;
    wait_cyc(m_osr * m_div);

    uart_net = 1'b0; wait_cyc(3 * m_div); uart_net = 1'b1;
    wait_cyc(3 * m_osr * m_div);
    chk("glitch.no_fv", fv_cnt, exp_fv);
    do_frame("post_glitch", 8'h0A, 1'b0, 1'b0, 1'b0);

    // LCR write landing on the start-edge cycle governs that frame
    set_cfg(1'b0, 2, 8'h03);
    model_cfg(1'b0, 2, 8'h0B);
    fork
      do_frame("same_cyc", 8'h01, 1'b0, 1'b0, 1'b0);
      begin @(negedge pclk); apb_write(32'h0C, 32'h0B, 4'hF, 1'b1); end
    join

    fork
      do_frame("mid_old", 8'h3D, 1'b0, 1'b0, 1'b0);
      begin wait_cyc(3 * m_osr * m_div); apb_write(32'h0C, 32'h03, 4'hF, 1'b1); end
    join
    model_cfg(1'b0, 2, 8'h03);
    do_frame("mid_new", 8'hC3, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      logic osr13 = 1'($urandom_range(0, 1));
      int dll = $urandom_range(0, 3);
      logic [7:0] lcr = 8'($urandom_range(0, 31));
      set_cfg(osr13, dll, lcr);
      do_frame($sformatf("rnd%0d", k), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Reset in the middle of a frame abandons it
    set_cfg(1'b0, 2, 8'h03);
    uart_net = 1'b0; wait_cyc(32);
    uart_net = 1'b1; wait_cyc(16);
    preset = 1'b1;
    wait_cyc(2);
    chk("midrst.frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("midrst.frame_data", {24'd0, frame_data}, 32'd0);
    chk("midrst.parity_err", {31'd0, parity_err}, 32'd0);
    chk("midrst.frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst.err_cnt", {16'd0, err_cnt}, 32'd0);
    preset = 1'b0;
    wait_cyc(200);
    chk("midrst.no_fv", fv_cnt, exp_fv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
